// File: rtl/arcade_input_mapper.sv
// ---------------------------------------------------------------------------
// arcade_input_mapper
//
// Control-input front end for arcade cores. Sits between the HPS keyboard /
// joystick outputs and the game core's button inputs.
//
//   * PS/2 make/break events are latched into per-player key state
//     (keyboard covers players 0 and 1; higher players are joystick-only).
//   * Key state is ORed with each player's joystick word to form the
//     physical control vector.
//   * Directions are remapped for one of four screen rotations.
//   * Optional share mode ORs all players together.
//   * Coin requests produce fixed-width, edge-triggered, non-retriggerable
//     coin pulses.
//
// Parameters
//   PLAYERS     number of player channels (1..4)
//   COIN_PULSE  coin output high time in clk_sys cycles (>= 1)
//
// Ports
//   clk_sys          in   system clock, rising edge
//   reset            in   asynchronous, active-high reset
//   ps2_key          in   [10] event toggle, [9] pressed, [8] extended, [7:0] code
//   joystick         in   16 bits per player: [0] right [1] left [2] down
//                         [3] up [4] fire1 [5] fire2 [6] start [7] coin
//   rotate           in   0 none, 1 CCW90, 2 CW90, 3 180
//   share            in   1: every player sees the OR of all players
//   coin_from_start  in   1: start also requests a coin for that player
//   btn              out  6 bits per player {fire2, fire1, up, down, left, right}
//   start            out  start per player (registered)
//   coin             out  coin pulse per player
// ---------------------------------------------------------------------------
module arcade_input_mapper #(
    parameter int PLAYERS    = 2,
    parameter int COIN_PULSE = 16
) (
    input  logic                    clk_sys,
    input  logic                    reset,
    input  logic [10:0]             ps2_key,
    input  logic [16*PLAYERS-1:0]   joystick,
    input  logic [1:0]              rotate,
    input  logic                    share,
    input  logic                    coin_from_start,
    output logic [6*PLAYERS-1:0]    btn,
    output logic [PLAYERS-1:0]      start,
    output logic [PLAYERS-1:0]      coin
);

    // Keyboard only drives the first two players.
    localparam int KB_PLAYERS = (PLAYERS < 2) ? PLAYERS : 2;
    localparam int CW         = $clog2(COIN_PULSE + 1);

    // Key latch bit positions. Bits 0..7 line up with the joystick word;
    // the second start key gets its own latch so releasing one start key
    // does not cancel the other.
    localparam int K_RIGHT  = 0;
    localparam int K_LEFT   = 1;
    localparam int K_DOWN   = 2;
    localparam int K_UP     = 3;
    localparam int K_FIRE1  = 4;
    localparam int K_FIRE2  = 5;
    localparam int K_START  = 6;
    localparam int K_COIN   = 7;
    localparam int K_START2 = 8;

    // -----------------------------------------------------------------------
    // Scan-code decode. Arrow keys and ctrl ignore the E0 prefix bit; every
    // other key must arrive without it.
    // -----------------------------------------------------------------------
    function automatic logic [8:0] key_decode(
        input int         player,
        input logic       ext,
        input logic [7:0] code
    );
        logic [8:0] hit;
        hit = '0;
        if (player == 0) begin
            case (code)
                8'h74:   hit[K_RIGHT]  = 1'b1;
                8'h6B:   hit[K_LEFT]   = 1'b1;
                8'h72:   hit[K_DOWN]   = 1'b1;
                8'h75:   hit[K_UP]     = 1'b1;
                8'h14:   hit[K_FIRE2]  = 1'b1;
                8'h29:   hit[K_FIRE1]  = !ext;
                8'h16:   hit[K_START]  = !ext;
                8'h05:   hit[K_START2] = !ext;
                8'h2E:   hit[K_COIN]   = !ext;
                default: hit = '0;
            endcase
        end else begin
            case (code)
                8'h34:   hit[K_RIGHT]  = !ext;
                8'h23:   hit[K_LEFT]   = !ext;
                8'h2B:   hit[K_DOWN]   = !ext;
                8'h2D:   hit[K_UP]     = !ext;
                8'h1C:   hit[K_FIRE1]  = !ext;
                8'h1B:   hit[K_FIRE2]  = !ext;
                8'h1E:   hit[K_START]  = !ext;
                8'h06:   hit[K_START2] = !ext;
                8'h36:   hit[K_COIN]   = !ext;
                default: hit = '0;
            endcase
        end
        return hit;
    endfunction

    // -----------------------------------------------------------------------
    // Rotation remap of a {up, down, left, right} direction nibble from
    // physical to logical orientation.
    // -----------------------------------------------------------------------
    function automatic logic [3:0] rotate_dirs(
        input logic [1:0] rot,
        input logic [3:0] d
    );
        logic [3:0] l;
        case (rot)
            2'd1:    l = {d[K_LEFT],  d[K_RIGHT], d[K_DOWN],  d[K_UP]};
            2'd2:    l = {d[K_RIGHT], d[K_LEFT],  d[K_UP],    d[K_DOWN]};
            2'd3:    l = {d[K_DOWN],  d[K_UP],    d[K_RIGHT], d[K_LEFT]};
            default: l = d;
        endcase
        return l;
    endfunction

    // -----------------------------------------------------------------------
    // PS/2 event detect and key latches
    // -----------------------------------------------------------------------
    logic                           tog_q;
    logic                           ps2_event;
    logic [KB_PLAYERS-1:0][8:0]     key_hit;
    logic [KB_PLAYERS-1:0][8:0]     key_q;

    // A toggle edge is seen combinationally on the same clock it arrives, so
    // the latch updates on that edge.
    assign ps2_event = ps2_key[10] ^ tog_q;

    always_comb begin
        // NOTE: every combinational output gets a default before any
        // conditional logic so no latch is inferred.
        key_hit = '0;
        for (int kp = 0; kp < KB_PLAYERS; kp++) begin
            key_hit[kp] = key_decode(kp, ps2_key[8], ps2_key[7:0]);
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            tog_q <= 1'b0;
            key_q <= '0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // flop samples pre-edge values regardless of statement order.
            tog_q <= ps2_key[10];
            if (ps2_event) begin
                for (int kp = 0; kp < KB_PLAYERS; kp++) begin
                    key_q[kp] <= (key_q[kp] & ~key_hit[kp])
                               | (key_hit[kp] & {9{ps2_key[9]}});
                end
            end
        end
    end

    // -----------------------------------------------------------------------
    // Physical vector per player: keyboard OR joystick
    // -----------------------------------------------------------------------
    logic [PLAYERS-1:0][7:0] kb_vec;
    logic [PLAYERS-1:0][7:0] phys_vec;
    logic [PLAYERS-1:0][7:0] joy_hi_unused;

    for (genvar p = 0; p < PLAYERS; p++) begin : g_kb
        if (p < KB_PLAYERS) begin : g_mapped
            assign kb_vec[p] = {key_q[p][K_COIN],
                                key_q[p][K_START] | key_q[p][K_START2],
                                key_q[p][5:0]};
        end else begin : g_joy_only
            assign kb_vec[p] = '0;
        end
    end

    always_comb begin
        phys_vec      = '0;
        joy_hi_unused = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            phys_vec[p]      = kb_vec[p] | joystick[16*p +: 8];
            joy_hi_unused[p] = joystick[16*p + 8 +: 8];
        end
    end

    // -----------------------------------------------------------------------
    // Rotation, then share
    // -----------------------------------------------------------------------
    logic [PLAYERS-1:0][7:0] log_vec;
    logic [PLAYERS-1:0][7:0] out_vec;
    logic [7:0]              any_vec;
    logic [PLAYERS-1:0]      coin_req;

    always_comb begin
        log_vec  = '0;
        out_vec  = '0;
        any_vec  = '0;
        coin_req = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            // Fire, start and coin pass straight through; only directions move.
            log_vec[p] = {phys_vec[p][7:4], rotate_dirs(rotate, phys_vec[p][3:0])};
            any_vec    = any_vec | log_vec[p];
        end
        for (int p = 0; p < PLAYERS; p++) begin
            out_vec[p]  = share ? any_vec : log_vec[p];
            coin_req[p] = out_vec[p][K_COIN]
                        | (coin_from_start & out_vec[p][K_START]);
        end
    end

    // -----------------------------------------------------------------------
    // Registered button / start outputs
    // -----------------------------------------------------------------------
    logic [6*PLAYERS-1:0] btn_q;
    logic [PLAYERS-1:0]   start_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            btn_q   <= '0;
            start_q <= '0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                btn_q[6*p +: 6] <= out_vec[p][5:0];
                start_q[p]      <= out_vec[p][K_START];
            end
        end
    end

    assign btn   = btn_q;
    assign start = start_q;

    // -----------------------------------------------------------------------
    // Coin pulse generators
    //
    // A pulse starts only on a rising request seen while idle. req_q resets
    // to ones so a request already high when reset releases looks like a
    // level, not an edge, and cannot fire a coin.
    // -----------------------------------------------------------------------
    logic [PLAYERS-1:0]          req_q;
    logic [PLAYERS-1:0][CW-1:0]  coin_cnt;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            req_q    <= '1;
            coin_cnt <= '0;
        end else begin
            for (int p = 0; p < PLAYERS; p++) begin
                req_q[p] <= coin_req[p];
                if (coin_cnt[p] != '0) begin
                    coin_cnt[p] <= coin_cnt[p] - 1'b1;
                end else if (coin_req[p] && !req_q[p]) begin
                    coin_cnt[p] <= CW'(COIN_PULSE);
                end
            end
        end
    end

    // Decoded straight from the counter so an asserted reset drops the
    // pulse immediately.
    always_comb begin
        coin = '0;
        for (int p = 0; p < PLAYERS; p++) begin
            coin[p] = (coin_cnt[p] != '0);
        end
    end

endmodule

// File: tb/tb_arcade_input_mapper.sv
// ---------------------------------------------------------------------------
// tb_arcade_input_mapper
//
// Directed bench for arcade_input_mapper with PLAYERS=2, COIN_PULSE=16.
// Inputs change 1 time unit after a rising edge; outputs are sampled at the
// same offset after the following edge(s).
// ---------------------------------------------------------------------------
module tb_arcade_input_mapper;

    localparam int PLAYERS    = 2;
    localparam int COIN_PULSE = 16;

    logic                  clk_sys = 1'b0;
    logic                  reset;
    logic [10:0]           ps2_key;
    logic [16*PLAYERS-1:0] joystick;
    logic [1:0]            rotate;
    logic                  share;
    logic                  coin_from_start;
    logic [6*PLAYERS-1:0]  btn;
    logic [PLAYERS-1:0]    start;
    logic [PLAYERS-1:0]    coin;

    int errors = 0;
    int checks = 0;

    // Logical bit reached by each physical direction bit, per rotation.
    int rot_map [4][4] = '{'{0, 1, 2, 3},
                           '{2, 3, 1, 0},
                           '{3, 2, 0, 1},
                           '{1, 0, 3, 2}};

    arcade_input_mapper #(
        .PLAYERS    (PLAYERS),
        .COIN_PULSE (COIN_PULSE)
    ) dut (
        .clk_sys         (clk_sys),
        .reset           (reset),
        .ps2_key         (ps2_key),
        .joystick        (joystick),
        .rotate          (rotate),
        .share           (share),
        .coin_from_start (coin_from_start),
        .btn             (btn),
        .start           (start),
        .coin            (coin)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk_sys);
        #1;
    endtask

    task automatic send_key(input logic pressed, input logic ext, input logic [7:0] code);
        ps2_key = {~ps2_key[10], pressed, ext, code};
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset           = 1'b1;
        ps2_key         = '0;
        joystick        = '0;
        rotate          = 2'd0;
        share           = 1'b0;
        coin_from_start = 1'b0;
        step(2);
        check("reset_btn",   32'(btn),   32'h0);
        check("reset_start", 32'(start), 32'h0);
        check("reset_coin",  32'(coin),  32'h0);
        reset = 1'b0;
        step(1);

        // Keyboard right arrow: make then break, two-cycle latency.
        send_key(1'b1, 1'b0, 8'h74);
        step(1);
        check("kb_right_lat1", 32'(btn), 32'h000);
        step(1);
        check("kb_right_make", 32'(btn), 32'h001);
        send_key(1'b0, 1'b0, 8'h74);
        step(2);
        check("kb_right_break", 32'(btn), 32'h000);

        // Extended prefix is don't-care for arrows, must be 0 for others.
        send_key(1'b1, 1'b1, 8'h74);
        step(2);
        check("kb_right_ext", 32'(btn), 32'h001);
        send_key(1'b0, 1'b1, 8'h74);
        step(2);
        check("kb_right_ext_break", 32'(btn), 32'h000);
        send_key(1'b1, 1'b1, 8'h16);
        step(2);
        check("kb_start_ext_ignored", 32'(start), 32'h0);

        // Make and break on consecutive toggles (P1 fire1 = bit 10).
        send_key(1'b1, 1'b0, 8'h1C);
        step(1);
        send_key(1'b0, 1'b0, 8'h1C);
        step(1);
        check("kb_fast_make", 32'(btn), 32'h400);
        step(1);
        check("kb_fast_break", 32'(btn), 32'h000);

        // Player 1 joystick up, no rotation.
        joystick = 32'h0008_0000;
        step(1);
        check("joy_p1_up", 32'(btn), 32'h200);
        joystick = '0;
        step(1);

        // Rotation table, joystick path, one-cycle latency.
        for (int r = 0; r < 4; r++) begin
            for (int d = 0; d < 4; d++) begin
                rotate   = 2'(r);
                joystick = 32'(1) << d;
                step(1);
                check($sformatf("rot%0d_dir%0d", r, d), 32'(btn), 32'(1) << rot_map[r][d]);
            end
        end
        rotate   = 2'd3;
        joystick = 32'h10;
        step(1);
        check("rot3_fire1", 32'(btn), 32'h010);
        rotate   = 2'd0;
        joystick = '0;
        step(2);

        // Joystick coin held 40 cycles: exactly one 16-cycle pulse.
        joystick = 32'h80;
        for (int i = 1; i <= 40; i++) begin
            step(1);
            check($sformatf("coin_hold_c%0d", i), 32'(coin), (i <= COIN_PULSE) ? 32'h1 : 32'h0);
        end
        joystick = '0;
        step(2);

        // Re-trigger during the pulse is ignored.
        joystick = 32'h80;
        for (int i = 1; i <= 24; i++) begin
            step(1);
            check($sformatf("coin_retrig_c%0d", i), 32'(coin), (i <= COIN_PULSE) ? 32'h1 : 32'h0);
            if (i == 4) joystick = '0;
            if (i == 8) joystick = 32'h80;
        end
        joystick = '0;
        step(2);

        // Keyboard coin adds one cycle of latency.
        send_key(1'b1, 1'b0, 8'h2E);
        step(1);
        check("kb_coin_lat1", 32'(coin), 32'h0);
        step(1);
        check("kb_coin_lat2", 32'(coin), 32'h1);
        send_key(1'b0, 1'b0, 8'h2E);
        step(18);
        check("kb_coin_done", 32'(coin), 32'h0);

        // Start key with coin_from_start: start plus one coin pulse.
        coin_from_start = 1'b1;
        send_key(1'b1, 1'b0, 8'h16);
        step(1);
        check("cfs_start_lat1", 32'(start), 32'h0);
        step(1);
        check("cfs_start", 32'(start), 32'h1);
        check("cfs_coin_c1", 32'(coin), 32'h1);
        for (int i = 2; i <= 20; i++) begin
            step(1);
            check($sformatf("cfs_coin_c%0d", i), 32'(coin), (i <= COIN_PULSE) ? 32'h1 : 32'h0);
        end
        send_key(1'b0, 1'b0, 8'h16);
        step(2);
        check("cfs_start_rel", 32'(start), 32'h0);

        // Same key without coin_from_start: start only.
        coin_from_start = 1'b0;
        send_key(1'b1, 1'b0, 8'h16);
        step(2);
        check("nocfs_start", 32'(start), 32'h1);
        for (int i = 1; i <= 18; i++) begin
            step(1);
            check($sformatf("nocfs_coin_c%0d", i), 32'(coin), 32'h0);
        end
        send_key(1'b0, 1'b0, 8'h16);
        step(2);

        // Share mode with P1 right key (G).
        share = 1'b1;
        send_key(1'b1, 1'b0, 8'h34);
        step(2);
        check("share_on_g", 32'(btn), 32'h041);
        send_key(1'b0, 1'b0, 8'h34);
        step(2);
        check("share_on_g_rel", 32'(btn), 32'h000);
        share = 1'b0;
        send_key(1'b1, 1'b0, 8'h34);
        step(2);
        check("share_off_g", 32'(btn), 32'h040);
        send_key(1'b0, 1'b0, 8'h34);
        step(2);
        check("share_off_g_rel", 32'(btn), 32'h000);

        // Reset mid-pulse with coin held: immediate drop, no refire on release.
        joystick = 32'h80;
        step(5);
        check("rst_pulse_c5", 32'(coin), 32'h1);
        reset = 1'b1;
        #1;
        check("rst_async_drop", 32'(coin), 32'h0);
        step(2);
        reset = 1'b0;
        for (int i = 1; i <= 20; i++) begin
            step(1);
            check($sformatf("rst_held_c%0d", i), 32'(coin), 32'h0);
        end
        joystick = '0;
        step(1);
        joystick = 32'h80;
        step(1);
        check("rst_fresh_edge", 32'(coin), 32'h1);
        joystick = '0;
        step(18);
        check("rst_fresh_done", 32'(coin), 32'h0);

        // Toggle bit high at reset release counts as one event.
        reset   = 1'b1;
        ps2_key = {1'b1, 1'b1, 1'b0, 8'h74};
        step(2);
        check("rel_event_in_reset", 32'(btn), 32'h000);
        reset = 1'b0;
        step(1);
        check("rel_event_lat1", 32'(btn), 32'h000);
        step(1);
        check("rel_event_lat2", 32'(btn), 32'h001);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
